// File: rtl/fibonacci_binary_pkg.sv
// fibonacci_binary_pkg: widths, limits and FSM states shared by the Fibonacci-to-binary converter
package fibonacci_binary_pkg;
   localparam int FIB_W = 32;
   localparam int BIN_W = 16;
   localparam int ACC_W = 24;
   localparam int CNT_W = $clog2(FIB_W);
   localparam logic [ACC_W-1:0] BIN_MAX = ACC_W'(65535);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/fibonacci_binary_if.sv
// fibonacci_binary_if: start/code request and result bundle of the Fibonacci-to-binary converter
interface fibonacci_binary_if import fibonacci_binary_pkg::*; ();
   logic             begin_f_b;
   logic [FIB_W-1:0] input_fibonacci;
   logic [BIN_W-1:0] binary_out;
   logic             convert_done;
   logic             error;
   logic             overflow;
   modport master (output begin_f_b, output input_fibonacci, input binary_out, input convert_done, input error, input overflow);
   modport slave (input begin_f_b, input input_fibonacci, output binary_out, output convert_done, output error, output overflow);
endinterface

// File: rtl/fibonacci_binary_weight_gen.sv
// fib_weight_gen: Fibonacci weight pair, loaded with (1,2) and advanced one weight per step
module fib_weight_gen import fibonacci_binary_pkg::*; (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             advance,
   output logic [ACC_W-1:0] w_cur
);
   logic [ACC_W-1:0] w_next;
   // w_next after the final step is never used, so its wrap is harmless
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         w_cur  <= '0;
         w_next <= '0;
      end else if (load) begin
         w_cur  <= ACC_W'(1);
         w_next <= ACC_W'(2);
      end else if (advance) begin
         w_cur  <= w_next;
         w_next <= w_cur + w_next;
      end
endmodule

// File: rtl/fibonacci_binary.sv
// fibonacci_binary: bit-serial Zeckendorf-to-binary converter with adjacency error and 16-bit saturation
module fibonacci_binary import fibonacci_binary_pkg::*; (
   input logic               clk,
   input logic               rst,
   fibonacci_binary_if.slave bus
);
   state_t           state, state_nx;
   logic [FIB_W-1:0] sr;
   logic [ACC_W-1:0] acc, w_cur;
   logic [CNT_W-1:0] cnt;
   logic             prev, err_acc, start, run;
   logic [BIN_W-1:0] bin_q;
   logic             done_q, err_q, ovf_q;
   assign start = state == IDLE && bus.begin_f_b;
   assign run   = state == RUN;
   fib_weight_gen u_weight (
      .clk     (clk),
      .rst     (rst),
      .load    (start),
      .advance (run),
      .w_cur   (w_cur)
   );
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    state_nx = bus.begin_f_b ? RUN : IDLE;
         RUN:     state_nx = cnt == CNT_W'(FIB_W - 1) ? DONE : RUN;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end
   // non-standard codes are still summed; the adjacency only raises error
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         sr      <= '0;
         acc     <= '0;
         cnt     <= '0;
         prev    <= 1'b0;
         err_acc <= 1'b0;
      end else if (start) begin
         sr      <= bus.input_fibonacci;
         acc     <= '0;
         cnt     <= '0;
         prev    <= 1'b0;
         err_acc <= 1'b0;
      end else if (run) begin
         sr      <= sr >> 1;
         acc     <= sr[0] ? acc + w_cur : acc;
         cnt     <= cnt + 1'b1;
         prev    <= sr[0];
         err_acc <= err_acc | (sr[0] & prev);
      end
   // results hold between conversions and only update on DONE
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         bin_q  <= '0;
         done_q <= 1'b0;
         err_q  <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         done_q <= state == DONE;
         if (state == DONE) begin
            bin_q <= acc > BIN_MAX ? '1 : acc[BIN_W-1:0];
            ovf_q <= acc > BIN_MAX;
            err_q <= err_acc;
         end
      end
   assign bus.binary_out   = bin_q;
   assign bus.convert_done = done_q;
   assign bus.error        = err_q;
   assign bus.overflow     = ovf_q;
endmodule

// File: tb/tb_fibonacci_binary.sv
// tb_fibonacci_binary: scoreboard bench for the Fibonacci-to-binary converter
module tb_fibonacci_binary;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int total = 0;
   int bad = 0;
   logic [17:0] q[$];
   fibonacci_binary_if bus ();
   fibonacci_binary dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   function automatic logic [17:0] model(input logic [31:0] c);
      longint w0 = 1, w1 = 2, s = 0, t;
      for (int i = 0; i < 32; i++) begin
         if (c[i]) s += w0;
         t = w0 + w1;
         w0 = w1;
         w1 = t;
      end
      return {s > 65535 ? 16'hFFFF : 16'(s), |(c & (c >> 1)), s > 65535};
   endfunction
   function automatic logic [31:0] enc(input int v);
      longint w[32];
      logic [31:0] c = '0;
      longint r = v;
      w[0] = 1;
      w[1] = 2;
      for (int i = 2; i < 32; i++) w[i] = w[i-1] + w[i-2];
      for (int i = 31; i >= 0; i--)
         if (w[i] <= r) begin
            c[i] = 1'b1;
            r -= w[i];
         end
      return c;
   endfunction
   always @(negedge clk)
      if (bus.convert_done) begin
         check("sb_pending", q.size() != 0, 1);
         if (q.size() != 0) begin
            logic [17:0] e;
            e = q.pop_front();
            check("binary_out", bus.binary_out, e[17:2]);
            check("error", bus.error, e[1]);
            check("overflow", bus.overflow, e[0]);
         end
      end
   task automatic convert(input logic [31:0] code, input logic [17:0] exp, input bit pulse_mid);
      int lat = 0;
      @(posedge clk); #1;
      bus.begin_f_b = 1'b1;
      bus.input_fibonacci = code;
      q.push_back(exp);
      @(posedge clk); #1;
      bus.begin_f_b = 1'b0;
      bus.input_fibonacci = $urandom();
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (pulse_mid && i == 5) bus.begin_f_b = 1'b1;
         if (pulse_mid && i == 6) bus.begin_f_b = 1'b0;
         if (bus.convert_done) begin
            lat = i;
            break;
         end
      end
      check("latency", lat, 34);
      @(negedge clk);
      check("pulse_width", bus.convert_done, 0);
   endtask
   initial begin
      int n;
      logic [31:0] c;
      bus.begin_f_b = 1'b0;
      bus.input_fibonacci = '0;
      #2;
      check("rst_bin", bus.binary_out, 0);
      check("rst_done", bus.convert_done, 0);
      check("rst_err", bus.error, 0);
      check("rst_ovf", bus.overflow, 0);
      #10 rst = 1'b0;
      convert(32'h00000000, {16'd0, 1'b0, 1'b0}, 0);
      convert(32'h0000000A, {16'd7, 1'b0, 1'b0}, 0);
      convert(32'h00000001, {16'd1, 1'b0, 1'b0}, 0);
      convert(32'h00505204, {16'hFFFF, 1'b0, 1'b0}, 0);
      convert(32'h00800000, {16'hFFFF, 1'b0, 1'b1}, 0);
      convert(32'h00000003, {16'd3, 1'b1, 1'b0}, 0);
      convert(32'h0000000A, {16'd7, 1'b0, 1'b0}, 1);
      foreach (c[i]) if (i < 6) convert(enc(i), {16'(i), 1'b0, 1'b0}, 0);
      convert(enc(65535), {16'hFFFF, 1'b0, 1'b0}, 0);
      convert(enc(65534), {16'hFFFE, 1'b0, 1'b0}, 0);
      for (int k = 0; k < 40; k++) begin
         int v = $urandom_range(65535);
         convert(enc(v), {16'(v), 1'b0, 1'b0}, 0);
      end
      for (int k = 0; k < 12; k++) begin
         c = $urandom();
         convert(c, model(c), 0);
      end
      // back-to-back with begin_f_b held high
      @(posedge clk); #1;
      bus.begin_f_b = 1'b1;
      bus.input_fibonacci = 32'h00000015;
      q.push_back({16'd12, 1'b0, 1'b0});
      q.push_back({16'd12, 1'b0, 1'b0});
      @(posedge clk); #1;
      n = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (bus.convert_done) begin
            n = i;
            break;
         end
      end
      check("b2b_first_lat", n, 34);
      n = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (bus.convert_done) begin
            n = i;
            bus.begin_f_b = 1'b0;
            break;
         end
      end
      bus.begin_f_b = 1'b0;
      check("b2b_gap", n, 34);
      repeat (2) @(negedge clk);
      // leave nonzero results, then abort a run with reset
      convert(32'h00800003, {16'hFFFF, 1'b1, 1'b1}, 0);
      @(posedge clk); #1;
      bus.begin_f_b = 1'b1;
      bus.input_fibonacci = 32'h00505204;
      @(posedge clk); #1;
      bus.begin_f_b = 1'b0;
      repeat (10) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("abort_bin", bus.binary_out, 0);
      check("abort_err", bus.error, 0);
      check("abort_ovf", bus.overflow, 0);
      check("abort_done", bus.convert_done, 0);
      #2 rst = 1'b0;
      n = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.convert_done) n++;
      end
      check("abort_no_done", n, 0);
      convert(32'h0000000A, {16'd7, 1'b0, 1'b0}, 0);
      check("sb_drained", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
